// File: rtl/ab_interleave_sequencer.sv
// Grants a shared resource to requesters B, A, B, ... after a start rise.
// Optional violation flag and embedded assertions enabled by AB_SEQ_VIOL_CHECK_EN.
module ab_interleave_sequencer #(
    parameter int unsigned NUM_ROUNDS = 1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic done,
    output logic abort,
    output logic viol
);

    localparam int unsigned RW       = $clog2(NUM_ROUNDS + 1);
    localparam int unsigned TW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TMO_EN   = (TIMEOUT > 0);

    typedef enum logic [1:0] {IDLE, WAIT_B, WAIT_A, FINISH} state_t;

    state_t        state, state_n;
    logic [RW-1:0] round, round_n;
    logic [TW-1:0] tcnt, tcnt_n, tcnt_sat;
    logic          start_q;
    logic          rise;
    logic          tmo_hit;
    logic          gnt_a_n, gnt_b_n, busy_n, done_n, abort_n;

    assign rise     = start & ~start_q;
    assign tmo_hit  = TMO_EN && (tcnt == TW'(TMO_LAST));
    assign tcnt_sat = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            round   <= '0;
            tcnt    <= '0;
            start_q <= 1'b0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            abort   <= 1'b0;
        end else begin
            state   <= state_n;
            round   <= round_n;
            tcnt    <= tcnt_n;
            start_q <= start;
            gnt_a   <= gnt_a_n;
            gnt_b   <= gnt_b_n;
            busy    <= busy_n;
            done    <= done_n;
            abort   <= abort_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n = state;
        round_n = round;
        tcnt_n  = tcnt;
        gnt_a_n = 1'b0;
        gnt_b_n = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        abort_n = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = WAIT_B;
                    busy_n  = 1'b1;
                    round_n = '0;
                    tcnt_n  = '0;
                end
            end
            WAIT_B: begin
                if (req_b) begin
                    gnt_b_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = (round == RW'(NUM_ROUNDS)) ? FINISH : WAIT_A;
                end else if (tmo_hit) begin
                    abort_n = 1'b1;
                    busy_n  = 1'b0;
                    tcnt_n  = TW'(TIMEOUT);
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt_sat;
                end
            end
            WAIT_A: begin
                if (req_a) begin
                    gnt_a_n = 1'b1;
                    round_n = round + RW'(1);
                    tcnt_n  = '0;
                    state_n = WAIT_B;
                end else if (tmo_hit) begin
                    abort_n = 1'b1;
                    busy_n  = 1'b0;
                    tcnt_n  = TW'(TIMEOUT);
                    state_n = IDLE;
                end else begin
                    tcnt_n = tcnt_sat;
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef AB_SEQ_VIOL_CHECK_EN
    logic a_ooo, b_ooo, a_ooo_q, b_ooo_q, viol_q, pend_a;

    assign a_ooo = (state == WAIT_B) & req_a;
    assign b_ooo = (state == WAIT_A) & req_b;
    assign viol  = viol_q;

    // Sticky flag: the same requester out of order on two consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_ooo_q <= 1'b0;
            b_ooo_q <= 1'b0;
            viol_q  <= 1'b0;
        end else begin
            a_ooo_q <= a_ooo;
            b_ooo_q <= b_ooo;
            if ((a_ooo & a_ooo_q) | (b_ooo & b_ooo_q)) viol_q <= 1'b1;
        end
    end

    // pend_a is high between a gnt_b and the gnt_a that must follow it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      pend_a <= 1'b0;
        else if (gnt_b)                  pend_a <= 1'b1;
        else if (gnt_a | done | abort)   pend_a <= 1'b0;
    end

    a_gnt_mutex: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
    a_b_order:   assert property (@(posedge clk) disable iff (!rst_n) gnt_b |-> !pend_a);
    a_a_order:   assert property (@(posedge clk) disable iff (!rst_n) gnt_a |-> pend_a);
`else
    assign viol = 1'b0;
`endif

endmodule

// File: doc/ab_interleave_sequencer.md
Name: ab_interleave_sequencer

Overview:
- Sequences two requesters, A and B, onto one shared resource after a start event.
- Grant order is fixed: B, then A, then B, repeated NUM_ROUNDS times. Every pair of B grants has exactly one A grant between them.
- Sits between the requesting agents and the shared resource. Generates the handshake pattern that the interleave assertion (b[->1], then a[->1], then b[->1] after $rose(start)) checks.

Parameters:
- NUM_ROUNDS, 1, number of A grants per sequence; the sequence issues NUM_ROUNDS A grants and NUM_ROUNDS+1 B grants.
- TIMEOUT, 16, max cycles spent waiting for the expected request before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; its 0->1 transition, detected internally, launches a sequence.
- req_a  in  1  A request, level; held until granted.
- req_b  in  1  B request, level; held until granted.
- gnt_a  out  1  single-cycle A grant pulse.
- gnt_b  out  1  single-cycle B grant pulse.
- busy  out  1  high while a sequence is in progress.
- done  out  1  single-cycle pulse when a sequence completes normally.
- abort  out  1  single-cycle pulse when a sequence ends on timeout.
- viol  out  1  sticky protocol-violation flag; see Optional Feature.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; gnt_a, gnt_b, busy, done, abort, viol = 0.
  - round counter = 0; timeout counter = 0; start_q = 0.
- Start detection:
  - start_q registers start each cycle.
  - Rise = start & ~start_q.
  - A rise is acted on only in IDLE. A rise while busy is ignored and does not restart the sequence.
- States: IDLE, WAIT_B, WAIT_A, FINISH.
- IDLE:
  - On rise: go to WAIT_B, busy=1 from the next cycle, round=0, timeout=0.
- WAIT_B:
  - If req_b is sampled 1: gnt_b=1 for the next cycle only and timeout=0.
  - If round==NUM_ROUNDS, go to FINISH; otherwise go to WAIT_A.
  - req_a is ignored in this state; no gnt_a is issued.
- WAIT_A:
  - If req_a is sampled 1: gnt_a=1 for the next cycle only, round increments, timeout=0, go to WAIT_B.
  - req_b is ignored in this state.
- Simultaneous req_a and req_b: only the request expected by the current state is granted. The other stays pending.
- Grant latency: exactly 1 cycle from the edge that samples the request to the grant cycle. gnt_a and gnt_b are never high in the same cycle.
- FINISH: done=1 for one cycle, busy=0 in that same cycle, then go to IDLE.
- Grants per sequence:
  - Minimum 2*NUM_ROUNDS+1 cycles from the first grant to done, when requests are continuously asserted.
  - In that case grants alternate B, A, B, ... on consecutive cycles.
- Timeout (TIMEOUT>0):
  - The timeout counter increments every cycle spent in WAIT_A or WAIT_B without the expected request.
  - When it reaches TIMEOUT: abort=1 for one cycle, busy=0, go to IDLE. No grant is issued in that cycle.
- Counter widths:
  - round counter: $clog2(NUM_ROUNDS+1) bits, never wraps.
  - timeout counter: $clog2(TIMEOUT+1) bits, saturates at TIMEOUT.
- Reset mid-sequence: all outputs drop to 0 immediately (asynchronous). Pending requests are forgotten, and a new rise is required to start again.
- start held high across a completed sequence: no re-launch until start goes low and rises again.

Optional Feature:
- Macro: AB_SEQ_VIOL_CHECK_EN.
- Defined:
  - viol is set, and stays set until reset, if req_a is high in WAIT_B, or req_b is high in WAIT_A, for 2 or more consecutive cycles (an out-of-order requester).
  - Embedded assertions are compiled in:
    - gnt_a and gnt_b are mutually exclusive.
    - After each gnt_b, exactly one gnt_a occurs before the next gnt_b within a sequence.
- Not defined: viol is tied to 0 and no assertions are compiled. Grant behaviour is identical in both builds.

Test Plan:
- NUM_ROUNDS=1; start rises at cycle 1; req_b at cycle 3, req_a at cycle 5, req_b at cycle 7, each held until granted -> gnt_b at 4, gnt_a at 6, gnt_b at 8, done at 9, busy high cycles 2-8.
- NUM_ROUNDS=3; req_a and req_b held high throughout -> grants B,A,B,A,B,A,B on 7 consecutive cycles; done 1 cycle after the last gnt_b; never both grants in one cycle.
- TIMEOUT=4; after gnt_b, req_a never asserts -> abort pulse 4 cycles after entering WAIT_A, no further grants, busy=0.
- A second start rise while busy -> ignored; the sequence completes with exactly NUM_ROUNDS+1 gnt_b and 1 done.
- rst_n pulsed low between gnt_b and gnt_a -> all outputs 0 immediately; no grants afterwards until a new start rise.
- AB_SEQ_VIOL_CHECK_EN defined; req_a held high for 3 cycles in WAIT_B -> viol=1 and stays 1 until rst_n. Same stimulus without the macro -> viol=0.
